// File: rtl/matrix_tile_serializer_if.sv
// matrix_tile_serializer_if
//   Tile-in / row-out handshake bundle for matrix_tile_serializer.
//   in_val/in_ready/in_elements : parallel tile, NUM_MG rows x NUM_PE elements
//   out_val/out_ready           : per-beat handshake toward downstream
//   out_row/out_idx/out_last    : current beat, its index, final-beat flag
//   modport slave  : serializer side
//   modport master : producer/consumer (test or surrounding logic) side
interface matrix_tile_serializer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG     = 8,
  parameter int NUM_PE     = 8
);
  localparam int IDX_W = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;

  logic                                         in_val;
  logic                                         in_ready;
  logic [NUM_MG-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] in_elements;
  logic                                         out_val;
  logic                                         out_ready;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0]            out_row;
  logic [IDX_W-1:0]                             out_idx;
  logic                                         out_last;

  modport slave (
    input  in_val, in_elements, out_ready,
    output in_ready, out_val, out_row, out_idx, out_last
  );

  modport master (
    output in_val, in_elements, out_ready,
    input  in_ready, out_val, out_row, out_idx, out_last
  );
endinterface

// File: rtl/matrix_tile_serializer.sv
// matrix_tile_serializer
//   Captures a full NUM_MG x NUM_PE tile in one handshake and emits it as
//   NUM_MG beats of NUM_PE elements under valid/ready backpressure.
//   Ports:
//     clk, rst       : clock, asynchronous active-high reset
//     bus (slave)    : tile input / row output handshake (see _if file)
//     tiles_done     : saturating 16-bit count of fully emitted tiles
//     tile_transpose : (SERIALIZER_TRANSPOSE_EN only) sampled with an accepted
//                      tile; when set, beat k carries column k instead of row k
//   Optional feature macro: SERIALIZER_TRANSPOSE_EN (requires NUM_MG == NUM_PE).

// One output lane: picks element sel out of its NUM_MG-deep source vector.
module matrix_tile_serializer_lane #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG     = 8,
  parameter int IDX_W      = 3
) (
  input  logic [NUM_MG-1:0][DATA_WIDTH-1:0] src,
  input  logic [IDX_W-1:0]                  sel,
  output logic [DATA_WIDTH-1:0]             elem
);
  assign elem = src[sel];
endmodule

module matrix_tile_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG     = 8,
  parameter int NUM_PE     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef SERIALIZER_TRANSPOSE_EN
  input  logic                           tile_transpose,
`endif
  matrix_tile_serializer_if.slave        bus,
  output logic [15:0]                    tiles_done
);
  localparam int               IDX_W    = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MG - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                         state_q, state_d;
  logic [NUM_MG-1:0][NUM_PE-1:0][DATA_WIDTH-1:0]  tile_q;
  logic [IDX_W-1:0]                               cnt_q;
  logic [15:0]                                    tiles_done_q;
  logic                                           accept, beat, done;

  assign accept = bus.in_val  && bus.in_ready;
  assign beat   = bus.out_val && bus.out_ready;
  assign done   = beat && bus.out_last;

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_val) state_d = SEND;
      SEND:    if (bus.out_ready && (cnt_q == LAST_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    bus.in_ready = (state_q == IDLE);
    bus.out_val  = (state_q == SEND);
    bus.out_last = (state_q == SEND) && (cnt_q == LAST_IDX);
    bus.out_idx  = cnt_q;
  end

  // ---- tile storage and beat counter ----
  // Storage is only written on an accepted tile, so in_val seen while
  // sending can never disturb the tile being emitted.
`ifdef SERIALIZER_TRANSPOSE_EN
  logic xpose_q;

  if (NUM_MG != NUM_PE) begin : g_bad_shape
    $error("matrix_tile_serializer: transpose requires NUM_MG == NUM_PE");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         xpose_q <= 1'b0;
    else if (accept) xpose_q <= tile_transpose;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      tile_q <= bus.in_elements;
      cnt_q  <= '0;
    end else if (beat && !bus.out_last) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Counter is written only on an increment, so it holds any value between
  // increments (saturates at all-ones).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     tiles_done_q <= '0;
    else if (done && (tiles_done_q != 16'hFFFF)) tiles_done_q <= tiles_done_q + 16'd1;
  end

  assign tiles_done = tiles_done_q;

  // ---- output lanes: lane j gathers its candidate elements across beats ----
  for (genvar j = 0; j < NUM_PE; j++) begin : g_lane
    logic [NUM_MG-1:0][DATA_WIDTH-1:0] src;

    always_comb begin
      for (int i = 0; i < NUM_MG; i++) begin
        src[i] = tile_q[i][j];
`ifdef SERIALIZER_TRANSPOSE_EN
        // Transposed: beat i emits column i, so lane j takes element[j][i].
        if (xpose_q) src[i] = tile_q[j][i];
`endif
      end
    end

    matrix_tile_serializer_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_MG     (NUM_MG),
      .IDX_W      (IDX_W)
    ) u_lane (
      .src  (src),
      .sel  (cnt_q),
      .elem (bus.out_row[j])
    );
  end
endmodule

// File: tb/tb_matrix_tile_serializer.sv
module tb_matrix_tile_serializer;
  localparam int DW = 64;
  localparam int MG = 8;
  localparam int PE = 8;

  typedef logic [MG-1:0][PE-1:0][DW-1:0] tile_t;
  typedef logic [PE-1:0][DW-1:0]         row_t;

  typedef struct {
    row_t       row;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  // table record: stimulus (base value, ready pattern) + expected cycle count
  typedef struct {
    logic [63:0] base;
    int          mode;     // 0 always ready, 1 toggle 1,0,1,0, 2 random
    int          exp_cyc;  // cycles from accept to last pop, -1 = don't care
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tiles_done;
`ifdef SERIALIZER_TRANSPOSE_EN
  logic        tile_transpose = 1'b0;
`endif

  matrix_tile_serializer_if #(.DATA_WIDTH(DW), .NUM_MG(MG), .NUM_PE(PE)) bus ();

  matrix_tile_serializer #(.DATA_WIDTH(DW), .NUM_MG(MG), .NUM_PE(PE)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef SERIALIZER_TRANSPOSE_EN
    .tile_transpose (tile_transpose),
`endif
    .bus            (bus),
    .tiles_done     (tiles_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       exp_q[$];
  logic [15:0] exp_done = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] elem(input logic [63:0] base, input int i, input int j);
    return base + 64'(16 * i + j);
  endfunction

  function automatic tile_t mk_tile(input logic [63:0] base);
    tile_t t;
    for (int i = 0; i < MG; i++)
      for (int j = 0; j < PE; j++)
        t[i][j] = elem(base, i, j);
    return t;
  endfunction

  task automatic push_tile(input logic [63:0] base, input bit xp);
    beat_t b;
    for (int k = 0; k < MG; k++) begin
      for (int j = 0; j < PE; j++)
        b.row[j] = xp ? elem(base, j, k) : elem(base, k, j);
      b.idx  = 3'(k);
      b.last = (k == MG - 1);
      exp_q.push_back(b);
    end
  endtask

  // Called #1 after a posedge while the DUT is idle: tile is taken next edge.
  task automatic drive_tile(input logic [63:0] base, input bit xp);
    bus.in_val      = 1'b1;
    bus.in_elements = mk_tile(base);
`ifdef SERIALIZER_TRANSPOSE_EN
    tile_transpose  = xp;
`endif
    push_tile(base, xp);
  endtask

  // Steps cycles from the accept edge until the scoreboard is empty.
  task automatic drain(input int mode, input bit keep_val, input logic [63:0] next_base,
                       output int cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      if (n == 0) begin
        if (keep_val) bus.in_elements = mk_tile(next_base);
        else          bus.in_val = 1'b0;
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (n % 2 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      n++;
      @(negedge clk); #1;
      if (n == 1) chk("latency_out_val", 512'(bus.out_val), 512'(1));
    end
    if (exp_q.size() != 0) chk("drain_timeout", 512'(exp_q.size()), 512'(0));
    cyc = n;
  endtask

  // Step into the cycle after the final beat: must be idle, count updated.
  task automatic finish_tile();
    @(posedge clk); #1;
    exp_done = (exp_done == 16'hFFFF) ? exp_done : exp_done + 16'd1;
    chk("idle_in_ready",  512'(bus.in_ready),  512'(1));
    chk("idle_out_val",   512'(bus.out_val),   512'(0));
    chk("tiles_done",     512'(tiles_done),    512'(exp_done));
  endtask

  // Output monitor: pops on every handshake, checks stability across stalls.
  initial begin : monitor
    bit    stall = 0;
    row_t  h_row;
    logic [2:0] h_idx;
    logic  h_last;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_val) begin
        if (stall) begin
          chk("hold_row",  512'(bus.out_row),  512'(h_row));
          chk("hold_idx",  512'(bus.out_idx),  512'(h_idx));
          chk("hold_last", 512'(bus.out_last), 512'(h_last));
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 512'(1), 512'(0));
          end else begin
            e = exp_q.pop_front();
            chk("beat_row",  512'(bus.out_row),  512'(e.row));
            chk("beat_idx",  512'(bus.out_idx),  512'(e.idx));
            chk("beat_last", 512'(bus.out_last), 512'(e.last));
          end
        end
        stall  = !bus.out_ready;
        h_row  = bus.out_row;
        h_idx  = bus.out_idx;
        h_last = bus.out_last;
      end else begin
        stall = 0;
      end
    end
  end

  vec_t vecs[5];

  initial begin
    int cyc;
    vecs[0] = '{base: 64'h0,                   mode: 0, exp_cyc: 8};
    vecs[1] = '{base: 64'h1000,                mode: 1, exp_cyc: 15};
    vecs[2] = '{base: 64'hABCD_0000_1234_0000, mode: 2, exp_cyc: -1};
    vecs[3] = '{base: 64'hFFFF_FFFF_FFFF_FF00, mode: 0, exp_cyc: 8};
    vecs[4] = '{base: 64'h55,                  mode: 1, exp_cyc: 15};

    bus.in_val      = 1'b0;
    bus.in_elements = '0;
    bus.out_ready   = 1'b0;

    // reset state
    #12;
    chk("rst_out_val",    512'(bus.out_val),  512'(0));
    chk("rst_in_ready",   512'(bus.in_ready), 512'(1));
    chk("rst_out_last",   512'(bus.out_last), 512'(0));
    chk("rst_out_idx",    512'(bus.out_idx),  512'(0));
    chk("rst_out_row",    512'(bus.out_row),  512'(0));
    chk("rst_tiles_done", 512'(tiles_done),   512'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // table-driven tiles
    for (int v = 0; v < 5; v++) begin
      drive_tile(vecs[v].base, 1'b0);
      drain(vecs[v].mode, 1'b0, '0, cyc);
      if (vecs[v].exp_cyc >= 0) chk("beat_cycles", 512'(cyc), 512'(vecs[v].exp_cyc));
      finish_tile();
    end

    // in_val held high with two distinct tiles back to back
    drive_tile(64'h7000, 1'b0);
    drain(0, 1'b1, 64'h9000, cyc);
    chk("held_cycles", 512'(cyc), 512'(8));
    finish_tile();           // one idle cycle; in_val still high with tile B
    push_tile(64'h9000, 1'b0);
    drain(0, 1'b0, '0, cyc);
    chk("held_b_cycles", 512'(cyc), 512'(8));
    finish_tile();

    // asynchronous reset in the middle of beat 3
    drive_tile(64'h2000, 1'b0);
    @(posedge clk); #1; bus.in_val = 1'b0; bus.out_ready = 1'b1;  // beat 0
    @(posedge clk); #1;                                           // beat 1
    @(posedge clk); #1;                                           // beat 2
    @(posedge clk); #1; bus.out_ready = 1'b0;                     // beat 3
    #1;
    chk("pre_rst_idx", 512'(bus.out_idx), 512'(3));
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_done = '0;
    chk("arst_out_val",    512'(bus.out_val),  512'(0));
    chk("arst_out_idx",    512'(bus.out_idx),  512'(0));
    chk("arst_in_ready",   512'(bus.in_ready), 512'(1));
    chk("arst_out_last",   512'(bus.out_last), 512'(0));
    chk("arst_out_row",    512'(bus.out_row),  512'(0));
    chk("arst_tiles_done", 512'(tiles_done),   512'(0));
    @(posedge clk); #1;
    chk("arst_hold_out_val", 512'(bus.out_val), 512'(0));
    #2 rst = 1'b0;
    @(posedge clk); #1;
    drive_tile(64'h3000, 1'b0);
    drain(0, 1'b0, '0, cyc);
    finish_tile();

`ifdef SERIALIZER_TRANSPOSE_EN
    // transposed tile: beat k carries column k
    drive_tile(64'h0, 1'b1);
    drain(0, 1'b0, '0, cyc);
    finish_tile();
    tile_transpose = 1'b0;
`endif

    // saturation of tiles_done
    force dut.tiles_done_q = 16'hFFFE;
    #10;
    release dut.tiles_done_q;
    exp_done = 16'hFFFE;
    chk("sat_preload", 512'(tiles_done), 512'(16'hFFFE));
    @(posedge clk); #1;
    for (int t = 0; t < 3; t++) begin
      drive_tile(64'h4000 + 64'(t * 256), 1'b0);
      drain(2, 1'b0, '0, cyc);
      finish_tile();
    end
    chk("sat_final", 512'(tiles_done), 512'(16'hFFFF));

    repeat (3) @(posedge clk);
    chk("queue_empty", 512'(exp_q.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/matrix_tile_serializer.md
MATRIX_TILE_SERIALIZER -- requirements
Module: matrix_tile_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving element width in bits.
REQ-002 The block SHALL have parameter NUM_MG, default 8, giving the number of tile rows (memory groups).
REQ-003 The block SHALL have parameter NUM_PE, default 8, giving the number of tile columns (processing elements).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_val, input, 1 bit, indicating a full tile is present on in_elements.
REQ-007 The block SHALL have port in_ready, output, 1 bit, indicating the block accepts a tile this cycle.
REQ-008 The block SHALL have port in_elements, input, [NUM_MG][NUM_PE] x DATA_WIDTH, carrying the parallel tile.
REQ-009 The block SHALL have port out_val, output, 1 bit, indicating out_row holds a valid beat.
REQ-010 The block SHALL have port out_ready, input, 1 bit, indicating downstream backpressure (beat consumed when out_val && out_ready).
REQ-011 The block SHALL have port out_row, output, [NUM_PE] x DATA_WIDTH, carrying the current row.
REQ-012 The block SHALL have port out_idx, output, $clog2(NUM_MG) bits, carrying the index of the current beat.
REQ-013 The block SHALL have port out_last, output, 1 bit, high on the final beat of a tile.
REQ-014 The block SHALL have port tiles_done, output, 16 bits, counting fully emitted tiles (saturating).

Function
REQ-015 The FSM SHALL have two states: IDLE and SEND.
REQ-016 In IDLE, in_ready SHALL be 1 and out_val 0; in SEND, in_ready SHALL be 0 and out_val 1.
REQ-017 When in_val && in_ready at edge N, all NUM_MG x NUM_PE elements SHALL be registered, the beat counter cleared to 0, and the FSM moved to SEND; out_val SHALL be 1 from cycle N+1 (latency 1).
REQ-018 In SEND, out_row SHALL equal the stored row out_idx, and out_idx SHALL equal the beat counter.
REQ-019 When out_val && !out_ready, out_row, out_idx and out_last SHALL hold stable.
REQ-020 When out_val && out_ready with counter < NUM_MG-1, the counter SHALL increment by 1.
REQ-021 out_last SHALL be 1 exactly when in SEND and counter == NUM_MG-1.
REQ-022 When out_val && out_ready && out_last, the FSM SHALL return to IDLE and tiles_done SHALL increment, saturating at 0xFFFF.
REQ-023 Consecutive tiles SHALL have exactly one IDLE cycle between them; in_val in SEND SHALL be ignored, and the stored tile SHALL not change.
REQ-024 The stored tile SHALL be written only on an accepted in_val.

Reset
REQ-025 On rst assertion, regardless of clock or state (including mid-tile), the FSM SHALL enter IDLE, the counter SHALL clear to 0, and tiles_done SHALL clear to 0.
REQ-026 During and after reset: out_val=0, in_ready=1, out_last=0, out_idx=0, out_row=0 (storage cleared to 0).
REQ-027 A partially emitted tile SHALL be discarded on reset and SHALL not count in tiles_done.

Configuration
REQ-028 Macro SERIALIZER_TRANSPOSE_EN SHALL, when defined, add input port tile_transpose (1 bit), sampled with an accepted in_val; if set, beat k SHALL emit column k (out_row[j] = element[j][k]); NUM_MG SHALL equal NUM_PE (elaboration error otherwise).
REQ-029 Without SERIALIZER_TRANSPOSE_EN, the port SHALL be absent and beats SHALL always be rows.

Verification
REQ-030 Element[i][j]=16*i+j, in_val one cycle, out_ready=1 -> out_val cycles 1..8, out_row[j]=16*k+j, out_last on beat 7, tiles_done=1.
REQ-031 Same tile, out_ready toggling 1,0,1,0 -> each beat held while stalled, 8 beats in order, no loss or duplication.
REQ-032 in_val held high constantly with two distinct tiles -> second tile accepted only in the IDLE cycle after beat 7; first tile's data unaltered.
REQ-033 rst pulsed asynchronously during beat 3 -> out_val=0 and out_idx=0 immediately, tiles_done=0, next tile starts at beat 0.
REQ-034 With SERIALIZER_TRANSPOSE_EN, tile_transpose=1, element[i][j]=16*i+j -> beat k out_row[j]=16*j+k.
REQ-035 Force tiles_done to 0xFFFE, emit 3 tiles -> tiles_done saturates at 0xFFFF.
